uart_wb_host: RTL and testbench

Command-driven Wishbone classic master that sits directly upstream of the UART 16550 Wishbone slave port. It turns single register access requests (valid/ready command, valid/ready response) into one Wishbone cycle each, handles byte-lane steering for 8-bit registers on the 32-bit bus, and bounds every cycle with a watchdog. It lets test sequencers and on-chip controllers program and poll the UART without driving bus signals cycle by cycle.

---
 rtl/uart_wb_pkg.sv | 30 +++
 rtl/uart_wb_watchdog.sv | 40 ++++
 rtl/uart_wb_host.sv | 148 ++++++++++++++
 tb/tb_uart_wb_host.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types, bus widths and byte-lane helpers for the UART Wishbone host.
package uart_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  function automatic logic [WB_SEL_W-1:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [WB_DATA_W-1:0] byte_insert(input logic [7:0] b,
                                                       input logic [1:0] lane);
    return {24'd0, b} << {lane, 3'b000};
  endfunction

  function automatic logic [7:0] byte_extract(input logic [WB_DATA_W-1:0] d,
                                              input logic [1:0] lane);
    logic [WB_DATA_W-1:0] s;
    s = d >> {lane, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/uart_wb_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since clear and flags the
// TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables it.
module uart_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled FSM never wraps the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = ENABLED && en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_wb_host.sv
// Command-driven Wishbone classic master for the UART 16550 register port:
// one bus cycle per command, byte-lane steering and a watchdog bound.
module uart_wb_host
  import uart_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [4:0]           cmd_addr,
  input  logic [7:0]           cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic                 wb_we_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  input  logic                 wb_ack_i
);

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;
  logic                 we_q, we_d;
  logic                 cyc_q, cyc_d;
  logic                 wd_clr, wd_en, wd_timeout;

  uart_wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .timeout_o(wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = BUS;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          cyc_d       = 1'b1;
          adr_d       = cmd_addr;
          we_d        = cmd_we;
          sel_d       = lane_sel(cmd_addr[1:0]);
          dat_d       = byte_insert(cmd_wdata, cmd_addr[1:0]);
          wd_clr      = 1'b1;
        end
      end
      BUS: begin
        wd_en = 1'b1;
        // Ack takes priority over a watchdog expiry in the same cycle.
        if (wb_ack_i || wd_timeout) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          adr_d       = '0;
          sel_d       = '0;
          dat_d       = '0;
          we_d        = 1'b0;
          rsp_err_d   = !wb_ack_i;
          rsp_rdata_d = (wb_ack_i && !we_q) ? byte_extract(wb_dat_i, adr_q[1:0]) : 8'd0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 8'd0;
          rsp_err_d   = 1'b0;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy_o    = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_uart_wb_host.sv
// Randomized self-checking bench for uart_wb_host against an arithmetic
// reference model of lane steering, ack/timeout latency and response data.
module tb_uart_wb_host;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [7:0]  rsp_rdata;
  logic [4:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o, wb_dat_i = '0;
  logic        wb_we, wb_stb, wb_cyc, wb_ack = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_wb_host #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy_o   (busy),
    .wb_adr_o (wb_adr),
    .wb_sel_o (wb_sel),
    .wb_dat_o (wb_dat_o),
    .wb_we_o  (wb_we),
    .wb_stb_o (wb_stb),
    .wb_cyc_o (wb_cyc),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble_cmd();
    cmd_we    = 1'($urandom);
    cmd_addr  = 5'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  // a: BUS cycle (1-based) in which the slave asserts ack; h: RESP cycles with rsp_ready low.
  task automatic txn(input bit we, input logic [4:0] addr, input logic [7:0] wd,
                     input int a, input logic [31:0] rbus, input int h);
    int          lane;
    int          lat;
    bit          tmo;
    logic [31:0] e_sel, e_dat, e_rd;
    lane  = int'(addr) % 4;
    tmo   = (T != 0) && (a > T);
    lat   = tmo ? T : a;
    e_sel = 32'd1 << lane;
    e_dat = 32'(wd) * (32'd1 << (8 * lane));
    e_rd  = (we || tmo) ? 32'd0 : ((rbus >> (8 * lane)) & 32'hff);

    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    rsp_ready = 1'b0; wb_ack = 1'b0;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    scramble_cmd();
    for (int k = 1; k <= lat; k++) begin
      check("bus_cyc", 32'(wb_cyc), 32'd1);
      check("bus_stb", 32'(wb_stb), 32'd1);
      check("bus_busy", 32'(busy), 32'd1);
      check("bus_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bus_rsp_valid", 32'(rsp_valid), 32'd0);
      check("bus_adr", 32'(wb_adr), 32'(addr));
      check("bus_we", 32'(wb_we), 32'(we));
      check("bus_sel", 32'(wb_sel), e_sel);
      check("bus_dat", wb_dat_o, e_dat);
      wb_ack   = (k == a);
      wb_dat_i = (k == a) ? rbus : $urandom;
      if (k == lat && h == 0) rsp_ready = 1'b1;
      tick();
    end
    wb_ack = 1'b0;
    wb_dat_i = $urandom;
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_err", 32'(rsp_err), 32'(tmo));
    check("resp_rdata", 32'(rsp_rdata), e_rd);
    check("resp_cyc_low", 32'(wb_cyc), 32'd0);
    check("resp_stb_low", 32'(wb_stb), 32'd0);
    check("resp_bus_zero", {wb_dat_o[31:10], wb_adr, wb_sel, wb_we},
          32'd0 | {22'd0, 5'd0, 4'd0, 1'b0});
    check("resp_dat_zero", wb_dat_o, 32'd0);
    check("resp_busy", 32'(busy), 32'd1);
    for (int j = 0; j < h; j++) begin
      cmd_valid = 1'b1;
      scramble_cmd();
      wb_ack = 1'($urandom);
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", 32'(rsp_rdata), e_rd);
      check("hold_err", 32'(rsp_err), 32'(tmo));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_no_cyc", 32'(wb_cyc), 32'd0);
    end
    wb_ack = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_no_cyc", 32'(wb_cyc), 32'd0);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", {24'd0, rsp_valid, rsp_err, busy, wb_we, wb_stb, wb_cyc, 2'b00}, 32'd0);
    check("rst_bus", wb_dat_o | {27'd0, wb_adr} | {28'd0, wb_sel} | {24'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(1'b1, 5'h03, 8'h83, 2, 32'hdead_beef, 0);
    txn(1'b0, 5'h05, 8'h00, 2, 32'h0060_0000, 0);
    txn(1'b0, 5'h02, 8'h11, 1000, 32'h1234_5678, 0);
    txn(1'b0, 5'h07, 8'h22, 4, 32'ha500_0000, 1);
    txn(1'b1, 5'h01, 8'h5a, 2, 32'h0, 10);
    txn(1'b0, 5'h1c, 8'h00, 1, 32'h0000_00c3, 2);
    txn(1'b1, 5'h12, 8'hff, 5, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 5'($urandom), 8'($urandom), int'($urandom_range(1, 6)),
          $urandom, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a bus cycle drops the command.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'h06; cmd_wdata = 8'h00;
    tick();
    cmd_valid = 1'b0;
    check("pre_rst_stb", 32'(wb_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {24'd0, rsp_valid, rsp_err, busy, wb_we, wb_stb, wb_cyc, 2'b00}, 32'd0);
    check("mid_rst_bus", wb_dat_o | {27'd0, wb_adr} | {28'd0, wb_sel} | {24'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    wb_ack = 1'b1;
    wb_dat_i = 32'hffff_ffff;
    tick();
    wb_ack = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("stray_no_rsp", 32'(rsp_valid), 32'd0);
      check("stray_no_cyc", 32'(wb_cyc), 32'd0);
      check("stray_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
    end
    txn(1'b0, 5'h0d, 8'h00, 2, 32'h0000_4200, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
